// File: rtl/mult_div_unit_if.sv
// Operand, move and result signals of the HI/LO multiply/divide unit.
// The master side issues operations and moves; the slave side is the unit itself.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Each operation takes one bit per cycle: 32 CALC cycles, then one FINISH cycle.
module mult_div_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wd,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        done_q, done_d;

    // Operand conditioning at the accept edge: signed ops work on magnitudes
    logic        op_signed, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag;

    assign op_signed = ~i_op[0];
    assign a_neg     = op_signed & i_a[31];
    assign b_neg     = op_signed & i_b[31];
    assign b_zero    = (i_b == 32'd0);
    assign a_mag     = a_neg ? (32'd0 - i_a) : i_a;
    assign b_mag     = b_neg ? (32'd0 - i_b) : i_b;

    // Shift-add multiply step: acc_lo holds the remaining multiplier bits
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);

    // Restoring divide step: acc_hi is the partial remainder, acc_lo the dividend/quotient
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    assign div_shift = {acc_hi_q, acc_lo_q[31]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_sub   = div_shift[31:0] - opb_q;

    logic [63:0] prod_res;
    logic [31:0] quo_res, rem_res;
    assign prod_res = neg_lo_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    assign quo_res  = neg_lo_q ? (32'd0 - acc_lo_q) : acc_lo_q;
    assign rem_res  = neg_hi_q ? (32'd0 - acc_hi_q) : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = CALC;
                    cnt_d    = 5'd0;
                    is_div_d = i_op[1];
                    opb_d    = b_mag;
                    acc_hi_d = 32'd0;
                    acc_lo_d = a_mag;
                    // A zero divisor leaves the quotient at all ones, so it is never negated
                    if (i_op[1]) begin
                        neg_lo_d = (a_neg ^ b_neg) & ~b_zero;
                        neg_hi_d = a_neg;
                    end else begin
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = 1'b0;
                    end
                end else begin
                    if (i_mthi) hi_d = i_wd;
                    if (i_mtlo) lo_d = i_wd;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (div_ge) begin
                        acc_hi_d = div_sub;
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    hi_d = prod_res[63:32];
                    lo_d = prod_res[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            opb_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, timing of busy/done,
// move handling and reset behaviour.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (bus.start),
        .i_op    (bus.op),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .i_mthi  (bus.mthi),
        .i_mtlo  (bus.mtlo),
        .i_wd    (bus.wd),
        .o_busy  (bus.busy),
        .o_done  (bus.done),
        .o_hi    (bus.hi),
        .o_lo    (bus.lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wd    = 32'd0;
    endtask

    // Issue one operation and follow it to the done cycle. With pokes set, moves accompany
    // the start and moves plus new starts are driven throughout the busy window.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit pokes);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (pokes) begin
            bus.mthi = 1'b1;
            bus.mtlo = 1'b1;
            bus.wd   = 32'hDEADBEEF;
        end
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        for (int cyc = 0; cyc < 33; cyc++) begin
            check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, " done_low"}, {31'd0, bus.done}, 32'd0);
            check({tag, " hi_held"}, bus.hi, m_hi);
            check({tag, " lo_held"}, bus.lo, m_lo);
            if (pokes) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
                bus.mtlo  = 1'b1;
                bus.wd    = 32'hAAAA5555;
            end
            tick();
        end
        clear_inputs();
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " hi"}, bus.hi, eh);
        check({tag, " lo"}, bus.lo, el);
        $display("op %s a=%h b=%h -> hi=%h lo=%h", tag, a, b, bus.hi, bus.lo);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst hi", bus.hi, 32'd0);
        check("rst lo", bus.lo, 32'd0);
        $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        tick();
        check("done_pulse", {31'd0, bus.done}, 32'd0);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("div_zero", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        run_op("divu_rem", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_pokes", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1);

        // Moves while idle: single, then both together
        tick();
        bus.mthi = 1'b1;
        bus.wd   = 32'h12345678;
        tick();
        clear_inputs();
        check("mthi hi", bus.hi, 32'h12345678);
        check("mthi lo", bus.lo, m_lo);
        check("mthi done", {31'd0, bus.done}, 32'd0);
        $display("mthi: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.wd   = 32'h0F0F0F0F;
        tick();
        clear_inputs();
        check("mtboth hi", bus.hi, 32'h0F0F0F0F);
        check("mtboth lo", bus.lo, 32'h0F0F0F0F);
        check("mtboth done", {31'd0, bus.done}, 32'd0);
        $display("mthi+mtlo: hi=%h lo=%h", bus.hi, bus.lo);
        m_hi = 32'h0F0F0F0F;
        m_lo = 32'h0F0F0F0F;

        // Reset ten cycles into an operation aborts it
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        tick();
        clear_inputs();
        for (int i = 0; i < 9; i++) tick();
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        $display("abort: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 30; i++) begin
            check("abort no_done", {31'd0, bus.done}, 32'd0);
            tick();
        end

        // Back-to-back: second start issued in the done cycle of the first
        run_op("b2b_5x6", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        run_op("b2b_2x3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        tick();
        check("b2b done_pulse", {31'd0, bus.done}, 32'd0);

        // Reset dominates start and moves in the same cycle
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wd    = 32'h55555555;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        check("rstdom busy", {31'd0, bus.busy}, 32'd0);
        check("rstdom hi", bus.hi, 32'd0);
        check("rstdom lo", bus.lo, 32'd0);
        $display("reset dominance: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
